key_event_decoder: RTL and testbench

- Consumes the debounced key level from the key debouncer, which runs at 50 MHz and holds a new level only after 20 ms of stability.
- Converts that level into single-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- Also drives a held-level flag.
- Sits between the key debouncer and the menu/control logic, so downstream blocks never deal with level or timing.

---
 rtl/key_event_decoder.sv | 155 +++++++++++++++
 tb/tb_key_event_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into single-cycle press/release/click/double-click/
// long/repeat pulses plus a held flag. All outputs are registered.
module key_event_decoder #(
  parameter logic        ACTIVE_LEVEL = 1'b0,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter int unsigned DCLICK_CYC   = 15_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_key_level,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_dclick,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PRESS1 = 3'd2,
    ST_LONG   = 3'd3,
    ST_GAP    = 3'd4,
    ST_PRESS2 = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DCL_LAST  = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_vld_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             pressed, timed, cnt_restart;

  assign pressed = (key_q == ACTIVE_LEVEL);
  assign timed   = (state_q == ST_PRESS1) || (state_q == ST_LONG) ||
                   (state_q == ST_GAP)    || (state_q == ST_PRESS2);

  always_comb begin
    state_d     = state_q;
    cnt_restart = 1'b0;
    press_d     = 1'b0;
    release_d   = 1'b0;
    click_d     = 1'b0;
    dclick_d    = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    case (state_q)
      // key_q holds its reset value until the first sample, so ARM waits for a real one
      ST_ARM: if (key_vld_q && !pressed) state_d = ST_IDLE;
      ST_IDLE: begin
        if (pressed) begin
          press_d = 1'b1;
          state_d = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (!pressed) begin
          release_d = 1'b1;
          state_d   = ST_GAP;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        if (!pressed) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == REP_LAST) begin
          repeat_d    = 1'b1;
          cnt_restart = 1'b1;
        end
      end
      ST_GAP: begin
        if (pressed) begin
          press_d = 1'b1;
          state_d = ST_PRESS2;
        end else if (cnt_q == DCL_LAST) begin
          click_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (!pressed) begin
          release_d = 1'b1;
          dclick_d  = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (state_d != state_q || cnt_restart || !timed) cnt_d = '0;
    else if (cnt_q == CNT_MAX)                        cnt_d = cnt_q;
    else                                              cnt_d = cnt_q + CNT_ONE;

    held_d = (state_d == ST_PRESS1) || (state_d == ST_PRESS2) || (state_d == ST_LONG);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_ARM;
      cnt_q     <= '0;
      key_q     <= ~ACTIVE_LEVEL;
      key_vld_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= I_key_level;
      key_vld_q <= 1'b1;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_dclick  = dclick_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: expected pulses derived from run lengths of the key stream.
module tb_key_event_decoder;

  localparam int LONG = 100;
  localparam int REP  = 20;
  localparam int DCL  = 30;
  localparam int MAXN = 2600;
  localparam int NEVER = 1 << 28;
  // expected-vector bit positions
  localparam int B_PRESS = 6, B_REL = 5, B_CLICK = 4, B_DCLICK = 3, B_LONG = 2, B_REP = 1, B_HELD = 0;

  logic I_clk = 1'b0;
  logic I_rst_n = 1'b0;
  logic I_key_level = 1'b1;
  logic o_press, o_release, o_click, o_dclick, o_long, o_repeat, o_held;

  logic       kin [0:MAXN-1];
  logic [6:0] expv [0:MAXN+1];
  int         wp;
  int         asserts = 0;
  int         fails = 0;

  key_event_decoder #(
    .ACTIVE_LEVEL(1'b0), .LONG_CYC(LONG), .REPEAT_CYC(REP), .DCLICK_CYC(DCL), .CNT_W(26)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_key_level(I_key_level),
    .o_press(o_press), .o_release(o_release), .o_click(o_click), .o_dclick(o_dclick),
    .o_long(o_long), .o_repeat(o_repeat), .o_held(o_held)
  );

  always #5 I_clk = ~I_clk;

  task automatic add_seg(input logic lvl, input int len);
    for (int i = 0; i < len; i++)
      if (wp < MAXN) begin kin[wp] = lvl; wp++; end
  endtask

  function automatic int find_lvl(input int from, input int n, input logic lvl);
    for (int i = from; i < n; i++) if (kin[i] == lvl) return i;
    return NEVER;
  endfunction

  task automatic setb(input int idx, input int b, input int n);
    if (idx >= 0 && idx <= n) expv[idx][b] = 1'b1;
  endtask

  task automatic set_held(input int from, input int to, input int n);
    for (int i = from; i <= to && i <= n; i++) expv[i][B_HELD] = 1'b1;
  endtask

  // Key sample k is seen by the decoder in cycle k; its consequence is visible at index k+1.
  task automatic compute(input int n);
    int a, p, e, r, g, q, l0;
    bit first, done;
    for (int i = 0; i <= n + 1 && i <= MAXN + 1; i++) expv[i] = '0;
    a = find_lvl(0, n, 1'b1);
    if (a >= n) return;
    a = a + 1;                                  // leaves ARM after first released sample
    while (a < n) begin
      p = find_lvl(a, n, 1'b0);
      if (p >= n) break;
      setb(p + 1, B_PRESS, n);
      e = p + 1;
      first = 1'b1;
      done = 1'b0;
      while (!done) begin
        r = find_lvl(e, n, 1'b1);
        if (r <= e + LONG - 1) begin
          set_held(e, r, n);
          setb(r + 1, B_REL, n);
          if (first) begin
            g = r + 1;
            q = find_lvl(g, n, 1'b0);
            if (q <= g + DCL - 1) begin
              setb(q + 1, B_PRESS, n);
              e = q + 1;
              first = 1'b0;
            end else begin
              setb(g + DCL, B_CLICK, n);
              a = g + DCL;
              done = 1'b1;
            end
          end else begin
            setb(r + 1, B_DCLICK, n);
            a = r + 1;
            done = 1'b1;
          end
        end else begin
          l0 = e + LONG;
          set_held(e, r, n);
          setb(l0, B_LONG, n);
          if (!first) setb(l0, B_CLICK, n);
          for (int c = l0 + REP - 1; c < r && c < n; c += REP) setb(c + 1, B_REP, n);
          setb(r + 1, B_REL, n);
          a = r + 1;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int cyc, input logic [6:0] e);
    logic [6:0] obs;
    obs = {o_press, o_release, o_click, o_dclick, o_long, o_repeat, o_held};
    asserts++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, e);
    end
  endtask

  // Reset (mid-sequence if a previous epoch was cut short), then play kin[0..n-1].
  task automatic run_epoch(input string tag, input int n);
    compute(n);
    @(negedge I_clk);
    I_rst_n = 1'b0;
    I_key_level = kin[0];
    #1 check({tag, "_rst"}, -1, 7'd0);
    @(negedge I_clk);
    check({tag, "_rst"}, -1, 7'd0);
    I_rst_n = 1'b1;
    for (int t = 1; t <= n; t++) begin
      @(negedge I_clk);
      check(tag, t - 1, expv[t - 1]);
      if (t < n) I_key_level = kin[t];
    end
  endtask

  function automatic int rand_press();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(1, 40);
      1:       return $urandom_range(95, 105);
      default: return $urandom_range(100, 170);
    endcase
  endfunction

  function automatic int rand_gap();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(1, 20);
      1:       return $urandom_range(27, 33);
      default: return $urandom_range(40, 60);
    endcase
  endfunction

  initial begin
    // held from reset, released, then a short tap
    wp = 0; add_seg(0, 50); add_seg(1, 10); add_seg(0, 10); add_seg(1, 50);
    run_epoch("arm_hold", wp);
    // single click
    wp = 0; add_seg(1, 5); add_seg(0, 10); add_seg(1, 50);
    run_epoch("click", wp);
    // double click
    wp = 0; add_seg(1, 5); add_seg(0, 10); add_seg(1, 15); add_seg(0, 10); add_seg(1, 50);
    run_epoch("dclick", wp);
    // long press with repeats
    wp = 0; add_seg(1, 5); add_seg(0, 165); add_seg(1, 50);
    run_epoch("long", wp);
    // release on the long threshold, press on the double-click timeout
    wp = 0; add_seg(1, 5); add_seg(0, 100); add_seg(1, 30); add_seg(0, 10); add_seg(1, 50);
    run_epoch("edge_rel", wp);
    wp = 0; add_seg(1, 5); add_seg(0, 101); add_seg(1, 31); add_seg(0, 10); add_seg(1, 50);
    run_epoch("edge_past", wp);
    // second press held long: click + long together
    wp = 0; add_seg(1, 5); add_seg(0, 10); add_seg(1, 10); add_seg(0, 130); add_seg(1, 40);
    run_epoch("p2_long", wp);
    // reset cut in GAP, LONG and PRESS2, each followed by a fresh epoch
    wp = 0; add_seg(1, 5); add_seg(0, 10); add_seg(1, 10);
    run_epoch("cut_gap", wp);
    wp = 0; add_seg(1, 60);
    run_epoch("after_gap", wp);
    wp = 0; add_seg(1, 5); add_seg(0, 130);
    run_epoch("cut_long", wp);
    wp = 0; add_seg(0, 20); add_seg(1, 40);
    run_epoch("after_long", wp);
    wp = 0; add_seg(1, 5); add_seg(0, 10); add_seg(1, 10); add_seg(0, 20);
    run_epoch("cut_p2", wp);
    wp = 0; add_seg(1, 5); add_seg(0, 10); add_seg(1, 50);
    run_epoch("after_p2", wp);
    // randomized key streams
    for (int ep = 0; ep < 8; ep++) begin
      wp = 0;
      add_seg(1'($urandom_range(0, 1)), $urandom_range(1, 20));
      add_seg(1, $urandom_range(1, 5));
      for (int s = 0; s < 8; s++) begin
        add_seg(0, rand_press());
        add_seg(1, rand_gap());
      end
      add_seg(1, 50);
      run_epoch("random", wp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
